// File: rtl/vote_tally.sv
// vote_tally: sync/debounce board inputs, snapshot switches on confirm and count yes-votes serially
module vote_db #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DB_CNT) + 1;
  logic s1_q, s2_q, lvl_q, p_q;
  logic [CW-1:0] cnt_q;
  // two-flop sync, then flip the level once it has differed for DB_CNT cycles; pulse on rising flip
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      lvl_q <= 1'b0;
      p_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      p_q <= 1'b0;
      if (s2_q == lvl_q) cnt_q <= '0;
      else if (cnt_q == CW'(DB_CNT - 1)) begin
        lvl_q <= ~lvl_q;
        cnt_q <= '0;
        p_q <= ~lvl_q;
      end else cnt_q <= cnt_q + 1'b1;
    end
  assign pulse_o = p_q;
endmodule

module vote_tally #(
  parameter int DB_CNT  = 1_000_000,
  parameter int PASS_TH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sw_i,
  input  logic       confirm_i,
  input  logic       clear_i,
  output logic [2:0] x_o,
  output logic       res_o,
  output logic       valid_o,
  output logic       busy_o
);
  localparam logic [1:0] IDLE = 2'd0, SAMPLE = 2'd1, COUNT = 2'd2, SHOW = 2'd3;
  logic cfm_p, clr_p;
  logic [4:0] sw1_q, sw2_q, snap_q, snap_d;
  logic [1:0] state_q, state_d;
  logic [2:0] acc_q, acc_d, idx_q, idx_d, x_q, x_d;
  logic res_q, res_d, valid_q, valid_d, busy_q, busy_d;

  vote_db #(.DB_CNT(DB_CNT)) u_cfm (.clk(clk), .rst_n(rst_n), .in_i(confirm_i), .pulse_o(cfm_p));
  vote_db #(.DB_CNT(DB_CNT)) u_clr (.clk(clk), .rst_n(rst_n), .in_i(clear_i), .pulse_o(clr_p));

  // next state: clear beats confirm, confirm only honoured when not counting
  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    acc_d = acc_q;
    idx_d = idx_q;
    if (clr_p) state_d = IDLE;
    else if (cfm_p && (state_q == IDLE || state_q == SHOW)) state_d = SAMPLE;
    else if (state_q == SAMPLE) state_d = COUNT;
    else if (state_q == COUNT && idx_q == 3'd4) state_d = SHOW;
    if (state_q == SAMPLE) begin
      snap_d = sw2_q;
      acc_d = '0;
      idx_d = '0;
    end else if (state_q == COUNT) begin
      acc_d = acc_q + {2'b00, snap_q[idx_q]};
      idx_d = idx_q + 3'd1;
    end
    valid_d = state_d == SHOW;
    busy_d = state_d == SAMPLE || state_d == COUNT;
    x_d = valid_d ? acc_d : 3'd0;
    res_d = valid_d && acc_d >= 3'(PASS_TH);
  end

  // state, datapath and output registers, switch synchronizer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw1_q <= '0;
      sw2_q <= '0;
      snap_q <= '0;
      state_q <= IDLE;
      acc_q <= '0;
      idx_q <= '0;
      x_q <= '0;
      res_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sw1_q <= sw_i;
      sw2_q <= sw1_q;
      snap_q <= snap_d;
      state_q <= state_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      x_q <= x_d;
      res_q <= res_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end

  assign x_o = x_q;
  assign res_o = res_q;
  assign valid_o = valid_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed stimulus against a cycle-level behavioural model of the vote front end
module tb_vote_tally;
  localparam int DB = 4;
  logic clk = 1'b0, rst_n = 1'b0, confirm = 1'b0, clear = 1'b0;
  logic [4:0] sw = '0;
  logic [2:0] x3, x5;
  logic r3, r5, v3, v5, b3, b5;
  int vec = 0, err = 0, cyc = 0;

  vote_tally #(.DB_CNT(DB), .PASS_TH(3)) u3 (.clk(clk), .rst_n(rst_n), .sw_i(sw), .confirm_i(confirm),
    .clear_i(clear), .x_o(x3), .res_o(r3), .valid_o(v3), .busy_o(b3));
  vote_tally #(.DB_CNT(DB), .PASS_TH(5)) u5 (.clk(clk), .rst_n(rst_n), .sw_i(sw), .confirm_i(confirm),
    .clear_i(clear), .x_o(x5), .res_o(r5), .valid_o(v5), .busy_o(b5));

  always #5 clk = ~clk;

  logic m_c1, m_c2, m_l1, m_l2, deb_c, deb_l, pc, pl, m_busy, m_valid;
  logic [4:0] m_sw1, m_sw2, m_snap;
  int run_c, run_l, m_start, m_x;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic m_reset();
    {m_c1, m_c2, m_l1, m_l2, deb_c, deb_l, pc, pl, m_busy, m_valid} = '0;
    m_sw1 = '0; m_sw2 = '0; m_snap = '0;
    run_c = 0; run_l = 0; m_start = -1; m_x = 0;
  endtask

  // a level must disagree with the debounced level for DB consecutive samples to be accepted
  task automatic db(input logic s, inout logic deb, inout int run, output logic p);
    p = 1'b0;
    if (s != deb) begin
      run++;
      if (run == DB) begin
        deb = s;
        run = 0;
        p = s;
      end
    end else run = 0;
  endtask

  task automatic m_step();
    cyc++;
    if (!rst_n) m_reset();
    else begin
      if (pl) begin
        m_busy = 0; m_valid = 0; m_x = 0; m_start = -1;
      end else if (pc && !m_busy) begin
        m_start = cyc; m_busy = 1; m_valid = 0; m_x = 0;
      end else if (m_busy) begin
        if (cyc == m_start + 1) m_snap = m_sw2;
        if (cyc == m_start + 6) begin
          m_busy = 0; m_valid = 1; m_x = $countones(m_snap);
        end
      end
      db(m_c2, deb_c, run_c, pc);
      db(m_l2, deb_l, run_l, pl);
      m_c2 = m_c1; m_c1 = confirm;
      m_l2 = m_l1; m_l1 = clear;
      m_sw2 = m_sw1; m_sw1 = sw;
    end
  endtask

  task automatic check_all();
    chk("x3", 32'(x3), 32'(m_x));
    chk("res3", 32'(r3), 32'(m_valid && m_x >= 3));
    chk("valid3", 32'(v3), 32'(m_valid));
    chk("busy3", 32'(b3), 32'(m_busy));
    chk("x5", 32'(x5), 32'(m_x));
    chk("res5", 32'(r5), 32'(m_valid && m_x >= 5));
    chk("valid5", 32'(v5), 32'(m_valid));
    chk("busy5", 32'(b5), 32'(m_busy));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      m_step();
      check_all();
    end
  endtask

  initial begin
    m_reset();
    #1;
    chk("rst_x", 32'(x3), 0);
    chk("rst_res", 32'(r3), 0);
    chk("rst_valid", 32'(v3), 0);
    chk("rst_busy", 32'(b3), 0);
    tick(2);
    rst_n = 1'b1;
    sw = 5'b10110;
    tick(3);
    confirm = 1'b1;
    tick(12);
    chk("lat12_valid", 32'(v3), 0);
    tick(1);
    chk("lat13_valid", 32'(v3), 1);
    chk("basic_x", 32'(x3), 3);
    chk("basic_res", 32'(r3), 1);
    confirm = 1'b0;
    tick(10);
    sw = 5'b00011;
    for (int k = 0; k < 3; k++) begin
      confirm = 1'b1; tick(2);
      confirm = 1'b0; tick(2);
    end
    confirm = 1'b1;
    tick(20);
    chk("bounce_x", 32'(x3), 2);
    chk("bounce_res", 32'(r3), 0);
    confirm = 1'b0;
    tick(10);
    sw = 5'b11111;
    tick(3);
    confirm = 1'b1;
    tick(9);
    sw = 5'b00000;
    tick(10);
    chk("snap_x", 32'(x3), 5);
    chk("snap_res5", 32'(r5), 1);
    confirm = 1'b0;
    tick(8);
    confirm = 1'b1;
    tick(20);
    chk("revote_x", 32'(x3), 0);
    chk("revote_valid", 32'(v3), 1);
    confirm = 1'b0;
    tick(8);
    confirm = 1'b1;
    clear = 1'b1;
    tick(12);
    chk("both_valid", 32'(v3), 0);
    confirm = 1'b0;
    clear = 1'b0;
    tick(8);
    sw = 5'b10101;
    confirm = 1'b1;
    tick(4);
    clear = 1'b1;
    tick(10);
    chk("clrmid_valid", 32'(v3), 0);
    chk("clrmid_x", 32'(x3), 0);
    confirm = 1'b0;
    clear = 1'b0;
    tick(8);
    sw = 5'b11100;
    confirm = 1'b1;
    tick(9);
    chk("pre_rst_busy", 32'(b3), 1);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_busy", 32'(b3), 0);
    check_all();
    tick(1);
    rst_n = 1'b1;
    tick(20);
    chk("post_rst_x", 32'(x3), 3);
    chk("post_rst_res", 32'(r3), 1);
    confirm = 1'b0;
    sw = 5'b11110;
    tick(8);
    confirm = 1'b1;
    tick(16);
    chk("th5_x4", 32'(x5), 4);
    chk("th5_res0", 32'(r5), 0);
    confirm = 1'b0;
    sw = 5'b11111;
    tick(8);
    confirm = 1'b1;
    tick(16);
    chk("th5_x5", 32'(x5), 5);
    chk("th5_res1", 32'(r5), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/vote_tally.md
# vote_tally

Sequential front end of the 5-voter DIP board: synchronizes the five vote switches, debounces the confirm and clear push-buttons, and on each confirm snapshots the switches and counts yes-votes serially. It sits between the board pins and the 7-segment display decoder. It produces the decoder's `x` input (vote count, 0..5) and `res` input (1 = motion passes), plus a `valid` qualifier.

## Interface
- `DB_CNT`, default 1_000_000: debounce stability length in clk cycles (10 ms at 100 MHz); set to 4 in simulation.
- `PASS_TH`, default 3: minimum yes-count for `res`=1; legal range 1..5.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in 5: raw DIP switches, 1 = yes vote; asynchronous to clk.
- `confirm` in 1: raw confirm push-button, active high, bouncing.
- `clear` in 1: raw clear push-button, active high, bouncing.
- `x` out 3: registered yes-count, 0..5; 0 whenever `valid`=0.
- `res` out 1: registered pass flag (`x` >= `PASS_TH`); 0 whenever `valid`=0.
- `valid` out 1: high while a completed count is displayed.
- `busy` out 1: high during SAMPLE and COUNT.

## Operation
- **Input synchronization:** `sw`, `confirm` and `clear` each pass through a 2-flop synchronizer.
- **Debouncers** (one each for confirm and clear):
  - Debounced level resets to 0.
  - A counter runs while the synchronized level differs from the debounced level and clears to 0 when they match. Any glitch therefore restarts it.
  - When the counter reaches `DB_CNT`-1, the debounced level flips and the counter clears.
  - A debounced 0→1 transition produces a one-cycle pulse: `cfm_p` or `clr_p`. Falling edges produce nothing.
  - A button held through reset release produces one pulse, `DB_CNT` cycles after sync.
- **FSM** (reset state IDLE):
  - IDLE: `valid`=0, `busy`=0. `cfm_p` → SAMPLE.
  - SAMPLE (1 cycle): latch synchronized `sw` into a snapshot; clear the accumulator and index to 0. → COUNT.
  - COUNT (5 cycles): each cycle add `snap[idx]` to a 3-bit accumulator and increment `idx`. After the cycle with `idx`=4 → SHOW.
  - SHOW: load `x` = accumulator and `res` = (accumulator >= `PASS_TH`); `valid`=1. Hold indefinitely.
  - SHOW + `cfm_p` → SAMPLE (re-vote). `valid`, `x` and `res` return to 0 from the next cycle.
- **Clear:** `clr_p` in any state → IDLE next cycle, with `x`, `res` and `valid` = 0.
- **Simultaneous `cfm_p` and `clr_p`:** clear wins.
- **`cfm_p` during SAMPLE or COUNT:** ignored; no restart, no queueing.
- **Switch changes after SAMPLE:** no effect on the count in progress; the result reflects the snapshot only.
- **Arithmetic:** the accumulator is 3 bits. The maximum value is 5, so no overflow is possible. The `PASS_TH` comparison is unsigned.
- **Reset:** asserting `rst_n` low at any time, including mid-COUNT, immediately forces:
  - FSM to IDLE;
  - all outputs to 0;
  - synchronizers, debounced levels, counters, snapshot and accumulator to 0.

## Timing
- **Reset values:** `x`=0, `res`=0, `valid`=0, `busy`=0.
- **Raw button to pulse:** a clean raw edge produces `cfm_p`/`clr_p` 2 + `DB_CNT` cycles later.
- **Confirm to result:** with `cfm_p` high in cycle t:
  - SAMPLE in t+1;
  - COUNT in t+2..t+6;
  - `valid`, `x` and `res` first high/updated in t+7.
- **`busy`:** high exactly t+1..t+6, i.e. 6 cycles.
- **Clear to idle:** `clr_p` in cycle t → `valid`=0 in t+1.
- **Registered outputs:** all outputs come from flops, with no combinational path from inputs.

## Test plan
- **Basic count:** `DB_CNT`=4, `sw`=5'b10110, clean confirm press → `busy` high 6 cycles, then `x`=3, `res`=1, `valid`=1; latency from raw edge = 2+4+7 = 13 cycles.
- **Bounce rejection:** confirm toggles 1/0 every 2 cycles for 12 cycles, then holds 1 → exactly one `cfm_p`, `DB_CNT` cycles after the final rise. With `sw`=5'b00011 the result is `x`=2, `res`=0.
- **Snapshot:** `sw`=5'b11111 at SAMPLE, then changed to 5'b00000 during COUNT → `x`=5, `res`=1. A later re-confirm gives `x`=0, `res`=0, with `valid` low for 6 cycles in between.
- **Clear priority:**
  - confirm and clear debounced pulses in the same cycle while in SHOW → IDLE, outputs 0;
  - clear mid-COUNT → IDLE, no result.
- **Reset mid-operation:** drop `rst_n` asynchronously during COUNT → outputs 0 immediately. Release with confirm held → one pulse after sync + `DB_CNT`, then a normal result.
- **Threshold parameter:** `PASS_TH`=5: `sw`=5'b11110 gives `x`=4, `res`=0; `sw`=5'b11111 gives `x`=5, `res`=1.
